frame_sync_receiver: RTL and testbench

FRAME_SYNC_RECEIVER -- requirements
Module: frame_sync_receiver

---
 rtl/frame_sync_pkg.sv | 24 ++
 rtl/alternation_counter.sv | 62 ++++++
 rtl/frame_sync_receiver.sv | 190 +++++++++++++++++++
 tb/tb_frame_sync_receiver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sync_pkg
//  Brief    : Shared state encoding and default delimiter for the frame
//             synchronising receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package frame_sync_pkg;

    // Receiver states; HUNT is the idle state and the only one with Busy low.
    typedef enum logic [2:0] {
        ST_HUNT       = 3'd0,
        ST_PREAMBLE   = 3'd1,
        ST_SFD_SEARCH = 3'd2,
        ST_HEADER     = 3'd3,
        ST_PARITY     = 3'd4,
        ST_PAYLOAD    = 3'd5
    } state_t;

    // Default start-of-frame delimiter, transmitted MSB first.
    localparam logic [7:0] C_DEFAULT_SFD = 8'b1101_0000;

endpackage
`default_nettype wire

// File: rtl/alternation_counter.sv
`default_nettype none
// ============================================================================
//  Module   : alternation_counter
//  Brief    : Tracks the length of the current run of alternating sampled
//             bits, saturating at MAX_COUNT.  o_count / o_qualified describe
//             the run including the bit presented on i_bit this cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module alternation_counter #(
    parameter int MAX_COUNT = 32,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_bit,
    input  logic             i_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_qualified
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic             r_prev;
    logic [CNT_W-1:0] w_next;
    logic             w_restart;

    // A zero count means no previous bit, so the next bit starts a new run.
    assign w_restart = (r_count == '0) || (i_bit == r_prev);

    // Run length after accepting the current bit, held at the ceiling.
    always_comb begin
        w_next = C_ONE;
        if (w_restart) begin
            w_next = C_ONE;
        end else if (r_count >= C_MAX) begin
            w_next = C_MAX;
        end else begin
            w_next = r_count + C_ONE;
        end
    end

    assign o_count     = i_valid ? w_next : r_count;
    assign o_qualified = i_valid && (w_next == C_MAX);

    // Run-length register; clear forgets the previous bit entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_prev  <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_valid) begin
            r_count <= w_next;
            r_prev  <= i_bit;
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_sync_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sync_receiver
//  Brief    : Serial frame receiver: preamble hunt, delimiter search, length
//             header with even parity, then payload forwarding with framing
//             pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_sync_receiver
    import frame_sync_pkg::*;
#(
    parameter int               PREAMBLE_MIN = 32,
    parameter int               SFD_W        = 8,
    parameter logic [SFD_W-1:0] SFD          = SFD_W'(C_DEFAULT_SFD),
    parameter int               LEN_W        = 12,
    parameter int               MAX_LEN      = 4095
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Input,
    input  logic             InputValid,
    output logic             Output,
    output logic             OutputValid,
    output logic             FrameStart,
    output logic             FrameEnd,
    output logic             Error,
    output logic [LEN_W-1:0] Length,
    output logic             Busy
);

    localparam int C_ALT_W     = $clog2(PREAMBLE_MIN + 1);
    localparam int C_SFD_CNT_W = $clog2(SFD_W + 1);
    localparam int C_HDR_CNT_W = $clog2(LEN_W + 1);

    localparam logic [C_ALT_W-1:0]     C_ALT_ONE  = C_ALT_W'(1);
    localparam logic [C_SFD_CNT_W-1:0] C_SFD_LAST = C_SFD_CNT_W'(SFD_W - 1);
    localparam logic [C_HDR_CNT_W-1:0] C_HDR_LAST = C_HDR_CNT_W'(LEN_W - 1);
    localparam logic [LEN_W-1:0]       C_MAX_LEN  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]       C_LEN_ONE  = LEN_W'(1);

    state_t                  r_state;
    logic [SFD_W-2:0]        r_sfd_hist;
    logic [C_SFD_CNT_W-1:0]  r_sfd_cnt;
    logic [LEN_W-1:0]        r_len_sr;
    logic [C_HDR_CNT_W-1:0]  r_hdr_cnt;
    logic [LEN_W-1:0]        r_pay_cnt;
    logic                    r_out;
    logic                    r_out_valid;
    logic                    r_frame_start;
    logic                    r_frame_end;
    logic                    r_error;
    logic [LEN_W-1:0]        r_length;
    logic                    r_busy;

    logic [SFD_W-1:0]        w_sfd_window;
    logic                    w_sfd_match;
    logic                    w_alt_clear;
    logic [C_ALT_W-1:0]      w_alt_count;
    logic                    w_alt_qualified;
    logic                    w_hdr_ok;

    // Last SFD_W sampled bits: stored history plus the bit arriving now.
    assign w_sfd_window = {r_sfd_hist, Input};
    assign w_sfd_match  = (w_sfd_window == SFD);

    // The run counter only lives while hunting or riding the preamble, so
    // every return to HUNT starts from an empty run.
    assign w_alt_clear = !((r_state == ST_HUNT) || (r_state == ST_PREAMBLE));

    // Length field is complete when the parity bit is on Input.
    assign w_hdr_ok = ~(^r_len_sr ^ Input) &&
                      (r_len_sr != '0) &&
                      (r_len_sr <= C_MAX_LEN);

    alternation_counter #(
        .MAX_COUNT (PREAMBLE_MIN),
        .CNT_W     (C_ALT_W)
    ) u_alt (
        .clk         (Clock),
        .rst         (Reset),
        .i_clear     (w_alt_clear),
        .i_bit       (Input),
        .i_valid     (InputValid),
        .o_count     (w_alt_count),
        .o_qualified (w_alt_qualified)
    );

    // Receiver state machine with registered outputs; advances on valid bits.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_HUNT;
            r_sfd_hist    <= '0;
            r_sfd_cnt     <= '0;
            r_len_sr      <= '0;
            r_hdr_cnt     <= '0;
            r_pay_cnt     <= '0;
            r_out         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_error       <= 1'b0;
            r_length      <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_out_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_error       <= 1'b0;
            if (InputValid) begin
                case (r_state)
                    ST_HUNT: begin
                        r_sfd_hist <= w_sfd_window[SFD_W-2:0];
                        if (w_alt_qualified) begin
                            r_state <= ST_PREAMBLE;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_PREAMBLE: begin
                        r_sfd_hist <= w_sfd_window[SFD_W-2:0];
                        // A restarted run means this bit repeated its
                        // predecessor; it is the first bit after the break.
                        if (w_alt_count == C_ALT_ONE) begin
                            r_state   <= ST_SFD_SEARCH;
                            r_sfd_cnt <= C_SFD_CNT_W'(1);
                        end
                    end
                    ST_SFD_SEARCH: begin
                        r_sfd_hist <= w_sfd_window[SFD_W-2:0];
                        if (w_sfd_match) begin
                            r_state   <= ST_HEADER;
                            r_hdr_cnt <= '0;
                        end else if (r_sfd_cnt == C_SFD_LAST) begin
                            r_state <= ST_HUNT;
                            r_busy  <= 1'b0;
                        end else begin
                            r_sfd_cnt <= r_sfd_cnt + C_SFD_CNT_W'(1);
                        end
                    end
                    ST_HEADER: begin
                        r_len_sr <= {r_len_sr[LEN_W-2:0], Input};
                        if (r_hdr_cnt == C_HDR_LAST) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_hdr_cnt <= r_hdr_cnt + C_HDR_CNT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (w_hdr_ok) begin
                            r_length      <= r_len_sr;
                            r_frame_start <= 1'b1;
                            r_pay_cnt     <= '0;
                            r_state       <= ST_PAYLOAD;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_HUNT;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_out       <= Input;
                        r_out_valid <= 1'b1;
                        // Compare against Length-1 so the counter never
                        // has to hold Length itself.
                        if (r_pay_cnt == (r_length - C_LEN_ONE)) begin
                            r_frame_end <= 1'b1;
                            r_state     <= ST_HUNT;
                            r_busy      <= 1'b0;
                        end else begin
                            r_pay_cnt <= r_pay_cnt + C_LEN_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_HUNT;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Output      = r_out;
    assign OutputValid = r_out_valid;
    assign FrameStart  = r_frame_start;
    assign FrameEnd    = r_frame_end;
    assign Error       = r_error;
    assign Length      = r_length;
    assign Busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_frame_sync_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_sync_receiver
//  Brief    : Self-checking bench for frame_sync_receiver.  Frames are built
//             from their fields; every driven bit carries the outputs that
//             the frame's construction says must follow it one cycle later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_sync_receiver;

    localparam int PRE_MIN = 32;
    localparam int LEN_W   = 12;
    localparam int MAX_LEN = 100;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             Input;
    logic             InputValid;
    logic             Output;
    logic             OutputValid;
    logic             FrameStart;
    logic             FrameEnd;
    logic             Error;
    logic [LEN_W-1:0] Length;
    logic             Busy;

    int tests     = 0;
    int fails     = 0;
    int exp_len   = 0;
    int last_busy = 0;

    typedef struct {
        bit ov;
        bit out;
        bit fs;
        bit fe;
        bit err;
        int busy;   // -1: not checked
        int len;    // new Length when fs is set
    } exp_t;

    frame_sync_receiver #(
        .PREAMBLE_MIN (PRE_MIN),
        .SFD_W        (8),
        .SFD          (8'b1101_0000),
        .LEN_W        (LEN_W),
        .MAX_LEN      (MAX_LEN)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Input       (Input),
        .InputValid  (InputValid),
        .Output      (Output),
        .OutputValid (OutputValid),
        .FrameStart  (FrameStart),
        .FrameEnd    (FrameEnd),
        .Error       (Error),
        .Length      (Length),
        .Busy        (Busy)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(bit ov, bit out, bit fs, bit fe, bit err, int busy, int len);
        exp_t e;
        e.ov = ov; e.out = out; e.fs = fs; e.fe = fe; e.err = err;
        e.busy = busy; e.len = len;
        return e;
    endfunction

    // Drive one cycle from a negedge, then check outputs at the next negedge.
    task automatic step(input bit v, input bit b, input exp_t e);
        Input      = b;
        InputValid = v;
        @(negedge Clock);
        if (e.fs) exp_len = e.len;
        check("OutputValid", {31'd0, OutputValid}, {31'd0, e.ov});
        if (e.ov) check("Output", {31'd0, Output}, {31'd0, e.out});
        check("FrameStart", {31'd0, FrameStart}, {31'd0, e.fs});
        check("FrameEnd", {31'd0, FrameEnd}, {31'd0, e.fe});
        check("Error", {31'd0, Error}, {31'd0, e.err});
        check("Length", {20'd0, Length}, exp_len);
        if (e.busy >= 0) check("Busy", {31'd0, Busy}, e.busy);
        last_busy = e.busy;
    endtask

    task automatic gap();
        step(1'b0, 1'b0, mk(0, 0, 0, 0, 0, last_busy, 0));
    endtask

    // gap_mode 0: none, 1: random idle cycles, 2: one idle cycle per bit.
    task automatic send(input bit b, input exp_t e, input int gap_mode);
        int n;
        n = 0;
        if (gap_mode == 2) n = 1;
        else if (gap_mode == 1 && $urandom_range(0, 3) == 0) n = int'($urandom_range(1, 3));
        repeat (n) gap();
        step(1'b1, b, e);
    endtask

    task automatic do_reset();
        Reset      = 1'b1;
        InputValid = 1'b0;
        Input      = 1'b0;
        @(negedge Clock);
        exp_len   = 0;
        last_busy = 0;
        check("rst_OutputValid", {31'd0, OutputValid}, 0);
        check("rst_Output", {31'd0, Output}, 0);
        check("rst_FrameStart", {31'd0, FrameStart}, 0);
        check("rst_FrameEnd", {31'd0, FrameEnd}, 0);
        check("rst_Error", {31'd0, Error}, 0);
        check("rst_Length", {20'd0, Length}, 0);
        check("rst_Busy", {31'd0, Busy}, 0);
        Reset = 1'b0;
    endtask

    // Build a frame from its fields; abort_after >= 0 resets after that
    // many payload bits.
    task automatic send_frame(input int pre_len, input bit start, input int len,
                              input bit bad_par, input int gap_mode, input int abort_after);
        logic [LEN_W-1:0] lf;
        logic [7:0]       sfd;
        bit               short_pre, accepted, rejected, par, b, last;
        int               pre_busy;
        lf        = LEN_W'(len);
        sfd       = 8'b1101_0000;
        short_pre = (pre_len < PRE_MIN);
        par       = (^lf) ^ bad_par;
        accepted  = !short_pre && !bad_par && (len >= 1) && (len <= MAX_LEN);
        rejected  = !short_pre && !accepted;
        pre_busy  = short_pre ? 0 : -1;
        for (int i = 0; i < pre_len; i++)
            send(start ^ ((i % 2) == 1), mk(0, 0, 0, 0, 0, pre_busy, 0), gap_mode);
        for (int i = 0; i < 8; i++)
            send(sfd[7-i], mk(0, 0, 0, 0, 0, pre_busy, 0), gap_mode);
        for (int i = 0; i < LEN_W; i++)
            send(lf[LEN_W-1-i], mk(0, 0, 0, 0, 0, short_pre ? 0 : 1, 0), gap_mode);
        send(par, mk(0, 0, accepted, 0, rejected, accepted ? 1 : 0, len), gap_mode);
        if (accepted) begin
            for (int k = 0; k < len; k++) begin
                if (k == abort_after) begin
                    do_reset();
                    return;
                end
                b    = 1'($urandom_range(0, 1));
                last = (k == len - 1);
                send(b, mk(1, b, 0, last, 0, last ? 0 : 1, 0), gap_mode);
            end
        end
    endtask

    initial begin
        Reset      = 1'b1;
        Input      = 1'b0;
        InputValid = 1'b0;
        do_reset();

        // Basic good frame, bad parity, short preamble, gapped frame.
        send_frame(96, 1'b1, 24, 1'b0, 0, -1);
        send_frame(96, 1'b1, 24, 1'b1, 0, -1);
        send_frame(16, 1'b1, 24, 1'b0, 0, -1);
        send_frame(96, 1'b1, 24, 1'b0, 2, -1);
        // Abort mid-payload, then a clean frame.
        send_frame(96, 1'b1, 24, 1'b0, 0, 10);
        send_frame(96, 1'b1, 24, 1'b0, 0, -1);
        // Length boundaries.
        send_frame(64, 1'b0, 0, 1'b0, 0, -1);
        send_frame(64, 1'b1, MAX_LEN + 1, 1'b0, 0, -1);
        send_frame(40, 1'b0, MAX_LEN, 1'b0, 1, -1);
        send_frame(33, 1'b1, 1, 1'b0, 0, -1);
        // Very long preamble and minimum-length preamble.
        send_frame(300, 1'b0, 17, 1'b0, 0, -1);
        send_frame(PRE_MIN, 1'b1, 9, 1'b0, 0, -1);
        send_frame(PRE_MIN, 1'b0, 9, 1'b0, 0, -1);

        for (int f = 0; f < 30; f++) begin
            int sel, pre, len, ab;
            bit bp;
            sel = int'($urandom_range(0, 9));
            pre = (sel == 0) ? int'($urandom_range(4, 16)) : int'($urandom_range(PRE_MIN, 80));
            len = int'($urandom_range(1, 60));
            bp  = 1'b0;
            ab  = -1;
            if (sel == 1) len = 0;
            else if (sel == 2) len = int'($urandom_range(MAX_LEN + 1, 4095));
            else if (sel == 3) bp = 1'b1;
            else if (sel == 4) ab = int'($urandom_range(0, len - 1));
            else if (sel == 5) len = MAX_LEN;
            send_frame(pre, 1'($urandom_range(0, 1)), len, bp, int'($urandom_range(0, 1)), ab);
        end

        repeat (4) gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
